// File: rtl/logic_shift_exec_pkg.sv
// logic_shift_exec_pkg: op codes and FSM states shared by the logic/shift execute stage
package logic_shift_exec_pkg;
  localparam logic [2:0] OP_XOR  = 3'b000;
  localparam logic [2:0] OP_ANDN = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_SLL  = 3'b101;
  localparam logic [2:0] OP_ROR  = 3'b110;
  localparam logic [2:0] OP_SRL  = 3'b111;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_SHIFT = 2'b01, ST_DONE = 2'b10} state_t;
endpackage

// File: rtl/logic_shift_exec_if.sv
// logic_shift_exec_if: operand-in / result-out handshake bundle of the execute stage
interface logic_shift_exec_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [15:0] A;
  logic [15:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Out;
  logic        zero;
  modport master (output in_valid, op, A, B, out_ready, input in_ready, out_valid, Out, zero);
  modport slave  (input in_valid, op, A, B, out_ready, output in_ready, out_valid, Out, zero);
endinterface

// File: rtl/shift1_16bit.sv
// shift1_16bit: single-bit rotate/shift step in the direction selected by the op code
module shift1_16bit
  import logic_shift_exec_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [15:0] i_d,
  output logic [15:0] o_q
);
  always_comb
    o_q = i_op == OP_ROL ? {i_d[14:0], i_d[15]} :
          i_op == OP_SLL ? {i_d[14:0], 1'b0} :
          i_op == OP_ROR ? {i_d[0], i_d[15:1]} :
                           {1'b0, i_d[15:1]};
endmodule

// File: rtl/xor_16bit.sv
// xor_16bit: 16-bit bitwise exclusive-or
module xor_16bit (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_y
);
  assign o_y = i_a ^ i_b;
endmodule

// File: rtl/logic_shift_exec.sv
// logic_shift_exec: one-cycle logic ops and bit-serial rotates/shifts with a registered result
module logic_shift_exec
  import logic_shift_exec_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic              clk,
  input logic              rst,
  logic_shift_exec_if.slave bus
);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_work, r_out, w_xor, w_logic, w_first, w_step;
  logic [3:0]       r_cnt;
  logic [2:0]       r_op;
  logic             r_zero, w_accept, w_direct;
  xor_16bit u_xor (.i_a(bus.A), .i_b(bus.B), .o_y(w_xor));
  shift1_16bit u_shift (.i_op(r_op), .i_d(r_work), .o_q(w_step));
  assign w_accept = bus.in_valid & bus.in_ready;
  // a zero-count shift is just a pass-through and finishes like a logic op
  assign w_direct = ~bus.op[2] | (bus.B[3:0] == 4'd0);
  always_comb begin
    w_logic = bus.op == OP_XOR  ? w_xor :
              bus.op == OP_ANDN ? bus.A & ~bus.B :
              bus.op == OP_OR   ? bus.A | bus.B :
                                  bus.A & bus.B;
    w_first = bus.op[2] ? bus.A : w_logic;
  end
  always_ff @(posedge clk)
    r_state <= !rst ? ST_IDLE : w_next;
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE:  w_next = w_accept ? (w_direct ? ST_DONE : ST_SHIFT) : ST_IDLE;
      ST_SHIFT: w_next = r_cnt == 4'd1 ? ST_DONE : ST_SHIFT;
      ST_DONE:  w_next = bus.out_ready ? ST_IDLE : ST_DONE;
      default:  w_next = ST_IDLE;
    endcase
  end
  always_comb begin
    bus.in_ready  = r_state == ST_IDLE;
    bus.out_valid = r_state == ST_DONE;
    bus.Out       = r_out;
    bus.zero      = r_zero;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_work <= '0;
      r_cnt  <= 4'd0;
      r_op   <= OP_XOR;
      r_out  <= '0;
      r_zero <= 1'b0;
    end else if (w_accept) begin
      r_work <= bus.A;
      r_cnt  <= bus.B[3:0];
      r_op   <= bus.op;
      if (w_direct) begin
        r_out  <= w_first;
        r_zero <= w_first == '0;
      end
    end else if (r_state == ST_SHIFT) begin
      r_work <= w_step;
      r_cnt  <= r_cnt - 4'd1;
      if (r_cnt == 4'd1) begin
        r_out  <= w_step;
        r_zero <= w_step == '0;
      end
    end
  end
endmodule
